// File: rtl/fpu_op_dispatcher.sv
// -----------------------------------------------------------------------------
// fpu_op_dispatcher
//   Front end of the FPU datapath. Accepts one FP operation request per
//   handshake, latches operands and op select, pulses a one-cycle start strobe
//   to the add/sub, mul or div unit, waits for that unit's done (bounded by a
//   timeout), then presents a response until the consumer accepts it.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   i_req_valid/o_req_ready  request handshake
//   i_req_sel                op select: 00 add, 01 sub, 10 mul, 11 div
//   i_req_a, i_req_b         operands
//   o_op_a, o_op_b           latched operands to all units
//   o_op_sub                 latched op is subtract
//   o_sel                    latched op select, to the result selector
//   o_start_add_sub/mul/div  one-cycle start strobes
//   i_done_add_sub           completion from the add/sub/mul path
//   i_done_div               completion from the div unit
//   o_busy                   operation in flight
//   o_resp_valid/i_resp_ready response handshake
//   o_resp_timeout           qualifies o_resp_valid: operation aborted
// -----------------------------------------------------------------------------
module fpu_op_dispatcher #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_sel,
  input  logic [DATA_W-1:0] i_req_a,
  input  logic [DATA_W-1:0] i_req_b,
  output logic [DATA_W-1:0] o_op_a,
  output logic [DATA_W-1:0] o_op_b,
  output logic              o_op_sub,
  output logic [1:0]        o_sel,
  output logic              o_start_add_sub,
  output logic              o_start_mul,
  output logic              o_start_div,
  input  logic              i_done_add_sub,
  input  logic              i_done_div,
  output logic              o_busy,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic              o_resp_timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic [1:0]        r_sel;
  logic              r_op_sub;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_timeout;
  logic              w_done;
  logic              w_timeout;

  // Only the unit that was started can complete the operation.
  assign w_done    = (r_sel == 2'b11) ? i_done_div : i_done_add_sub;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req_valid)          w_next = S_ISSUE;
      S_ISSUE:                           w_next = S_WAIT;
      // Completion and timeout both leave WAIT; the flag records which.
      S_WAIT:  if (w_done || w_timeout)  w_next = S_RESP;
      S_RESP:  if (i_resp_ready)         w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    o_req_ready     = 1'b0;
    o_busy          = 1'b1;
    o_resp_valid    = 1'b0;
    o_start_add_sub = 1'b0;
    o_start_mul     = 1'b0;
    o_start_div     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        o_busy      = 1'b0;
      end
      S_ISSUE: begin
        o_start_add_sub = ~r_sel[1];
        o_start_mul     = (r_sel == 2'b10);
        o_start_div     = (r_sel == 2'b11);
      end
      S_RESP:  o_resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, wait counter and timeout flag.
  // Operands and select are deliberately kept after returning to IDLE so the
  // result selector still sees the right sel while the result is consumed.
  // NOTE: only control and operand flops exist here, so all are reset; there
  // is no storage array that would need to be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_sel     <= 2'b00;
      r_op_sub  <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_req_valid) begin
        r_op_a   <= i_req_a;
        r_op_b   <= i_req_b;
        r_sel    <= i_req_sel;
        r_op_sub <= (i_req_sel == 2'b01);
      end

      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);

      // Completion beats a coincident timeout.
      if (r_state == S_WAIT && (w_done || w_timeout))
        r_timeout <= ~w_done;
      else if (r_state == S_RESP && i_resp_ready)
        r_timeout <= 1'b0;
    end
  end

  assign o_op_a         = r_op_a;
  assign o_op_b         = r_op_b;
  assign o_sel          = r_sel;
  assign o_op_sub       = r_op_sub;
  assign o_resp_timeout = r_timeout;

endmodule
